// File: rtl/cfr_ipif_pkg.sv
// Shared types and helpers for the CFR IPIF requester arbiter.
// Holds the channel FSM encoding, the read-timeout fill value and the round-robin search.
package cfr_ipif_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ipif_arb_state_t;

  localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Returns the first set bit of pending at or after start, wrapping modulo n (n <= 16).
  function automatic logic [3:0] rr_pick(input logic [15:0] pending,
                                         input logic [3:0]  start,
                                         input int          n);
    logic [3:0] pick;
    int         idx;
    pick = start;
    for (int k = 15; k >= 0; k--) begin
      idx = (int'(start) + k) % n;
      if (k < n && pending[idx]) pick = 4'(idx);
    end
    return pick;
  endfunction

endpackage

// File: rtl/cfr_ipif_arb_ch.sv
// One arbitrated IPIF channel: per-requester capture, round-robin grant, one outstanding
// downstream transaction, timeout with saturating event counter, optional per-requester return data.
module cfr_ipif_arb_ch
  import cfr_ipif_pkg::*;
#(
  parameter int               NUM_REQ     = 4,
  parameter int               FWD_W       = 42,
  parameter int               RET_W       = 32,
  parameter bit               RET_REG     = 1'b1,
  parameter int               TIMEOUT     = 255,
  parameter logic [RET_W-1:0] TIMEOUT_RET = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                s_req_i,
  input  logic [NUM_REQ-1:0][FWD_W-1:0]     s_fwd_i,
  output logic [NUM_REQ-1:0]                s_ack_o,
  output logic [NUM_REQ-1:0][RET_W-1:0]     s_ret_o,
  output logic                              m_req_o,
  output logic [FWD_W-1:0]                  m_fwd_o,
  input  logic                              m_ack_i,
  input  logic [RET_W-1:0]                  m_ret_i,
  output logic                              timeout_o,
  output logic [15:0]                       timeout_cnt_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = 16;

  ipif_arb_state_t               state_q, state_d;
  logic [NUM_REQ-1:0]            pend_q, pend_d, clr, cap, ack_q, ack_d;
  logic [NUM_REQ-1:0][FWD_W-1:0] fwd_q;
  logic [IDX_W-1:0]              ptr_q, ptr_d, gnt_q, gnt_d, pick;
  logic [TMR_W-1:0]              tmr_q, tmr_d;
  logic                          m_req_q, m_req_d, to_q, to_d, expired;
  logic [FWD_W-1:0]              m_fwd_q, m_fwd_d;
  logic [15:0]                   to_cnt_q, to_cnt_d;

  // A new request in the completion cycle re-arms pending and recaptures its payload.
  assign cap    = s_req_i & (~pend_q | clr);
  assign pend_d = s_req_i | (pend_q & ~clr);
  assign pick   = IDX_W'(rr_pick(16'(pend_q), 4'(ptr_q), NUM_REQ));

  always_comb begin
    // NOTE: every combinational output gets a default here so no path can infer a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    tmr_d    = tmr_q;
    m_req_d  = 1'b0;
    m_fwd_d  = m_fwd_q;
    ack_d    = '0;
    clr      = '0;
    to_d     = 1'b0;
    to_cnt_d = to_cnt_q;
    expired  = (TIMEOUT != 0) && (tmr_q == '0);
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          gnt_d   = pick;
          m_req_d = 1'b1;
          m_fwd_d = fwd_q[pick];
          tmr_d   = TMR_W'(TIMEOUT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (m_ack_i || expired) begin
          state_d       = IDLE;
          ack_d[gnt_q]  = 1'b1;
          clr[gnt_q]    = 1'b1;
          ptr_d         = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
          if (!m_ack_i) begin
            to_d = 1'b1;
            if (to_cnt_q != 16'hFFFF) to_cnt_d = to_cnt_q + 16'd1;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      tmr_q    <= '0;
      m_req_q  <= 1'b0;
      m_fwd_q  <= '0;
      ack_q    <= '0;
      to_q     <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      tmr_q    <= tmr_d;
      m_req_q  <= m_req_d;
      m_fwd_q  <= m_fwd_d;
      ack_q    <= ack_d;
      to_q     <= to_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // NOTE: payload storage has no reset; it is only read while its pending bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cap[i]) fwd_q[i] <= s_fwd_i[i];
    end
  end

  if (RET_REG) begin : g_ret
    logic [NUM_REQ-1:0][RET_W-1:0] ret_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        ret_q <= '0;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (ack_d[i]) ret_q[i] <= m_ack_i ? m_ret_i : TIMEOUT_RET;
        end
      end
    end
    assign s_ret_o = ret_q;
  end else begin : g_no_ret
    logic ret_unused;
    assign ret_unused = ^m_ret_i;
    assign s_ret_o    = '0;
  end

  assign s_ack_o       = ack_q;
  assign m_req_o       = m_req_q;
  assign m_fwd_o       = m_fwd_q;
  assign timeout_o     = to_q;
  assign timeout_cnt_o = to_cnt_q;

endmodule

// File: rtl/cfr_ipif_arbiter.sv
// Shares one downstream IPIF port between NUM_REQ requesters; write and read
// are independent round-robin channels, each with one transaction in flight.
module cfr_ipif_arbiter
  import cfr_ipif_pkg::*;
#(
  parameter int                         IPIF_ADDR_WIDTH = 10,
  parameter int                         IPIF_DATA_WIDTH = 32,
  parameter int                         NUM_REQ         = 4,
  parameter int                         TIMEOUT         = 255,
  parameter logic [IPIF_DATA_WIDTH-1:0] TIMEOUT_DATA    = IPIF_DATA_WIDTH'(TIMEOUT_DATA_DEFAULT)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ-1:0][IPIF_ADDR_WIDTH-1:0]       s_wr_addr,
  input  logic [NUM_REQ-1:0]                            s_wr_req,
  input  logic [NUM_REQ-1:0][IPIF_DATA_WIDTH-1:0]       s_wr_data,
  output logic [NUM_REQ-1:0]                            s_wr_ack,
  input  logic [NUM_REQ-1:0][IPIF_ADDR_WIDTH-1:0]       s_rd_addr,
  input  logic [NUM_REQ-1:0]                            s_rd_req,
  output logic [NUM_REQ-1:0][IPIF_DATA_WIDTH-1:0]       s_rd_data,
  output logic [NUM_REQ-1:0]                            s_rd_ack,
  output logic [IPIF_ADDR_WIDTH-1:0]                    wr_addr,
  output logic                                          wr_req,
  output logic [IPIF_DATA_WIDTH-1:0]                    wr_data,
  input  logic                                          wr_ack,
  output logic [IPIF_ADDR_WIDTH-1:0]                    rd_addr,
  output logic                                          rd_req,
  input  logic [IPIF_DATA_WIDTH-1:0]                    rd_data,
  input  logic                                          rd_ack,
  output logic                                          wr_timeout,
  output logic                                          rd_timeout,
  output logic [15:0]                                   wr_timeout_cnt,
  output logic [15:0]                                   rd_timeout_cnt
);

  localparam int WR_FWD_W = IPIF_ADDR_WIDTH + IPIF_DATA_WIDTH;

  logic [NUM_REQ-1:0][WR_FWD_W-1:0] wr_fwd;
  logic [WR_FWD_W-1:0]              wr_fwd_m;
  logic [NUM_REQ-1:0][0:0]          wr_ret_unused;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_wr_fwd
    assign wr_fwd[i] = {s_wr_addr[i], s_wr_data[i]};
  end
  assign {wr_addr, wr_data} = wr_fwd_m;

  cfr_ipif_arb_ch #(
    .NUM_REQ     (NUM_REQ),
    .FWD_W       (WR_FWD_W),
    .RET_W       (1),
    .RET_REG     (1'b0),
    .TIMEOUT     (TIMEOUT),
    .TIMEOUT_RET (1'b0)
  ) u_wr_ch (
    .clk           (clk),
    .rst           (rst),
    .s_req_i       (s_wr_req),
    .s_fwd_i       (wr_fwd),
    .s_ack_o       (s_wr_ack),
    .s_ret_o       (wr_ret_unused),
    .m_req_o       (wr_req),
    .m_fwd_o       (wr_fwd_m),
    .m_ack_i       (wr_ack),
    .m_ret_i       (1'b0),
    .timeout_o     (wr_timeout),
    .timeout_cnt_o (wr_timeout_cnt)
  );

  cfr_ipif_arb_ch #(
    .NUM_REQ     (NUM_REQ),
    .FWD_W       (IPIF_ADDR_WIDTH),
    .RET_W       (IPIF_DATA_WIDTH),
    .RET_REG     (1'b1),
    .TIMEOUT     (TIMEOUT),
    .TIMEOUT_RET (TIMEOUT_DATA)
  ) u_rd_ch (
    .clk           (clk),
    .rst           (rst),
    .s_req_i       (s_rd_req),
    .s_fwd_i       (s_rd_addr),
    .s_ack_o       (s_rd_ack),
    .s_ret_o       (s_rd_data),
    .m_req_o       (rd_req),
    .m_fwd_o       (rd_addr),
    .m_ack_i       (rd_ack),
    .m_ret_i       (rd_data),
    .timeout_o     (rd_timeout),
    .timeout_cnt_o (rd_timeout_cnt)
  );

endmodule

// File: tb/tb_cfr_ipif_arbiter.sv
// Directed bench for cfr_ipif_arbiter: inputs change and outputs are checked on the falling edge.
module tb_cfr_ipif_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0][9:0]   s_wr_addr, s_rd_addr;
  logic [3:0][31:0]  s_wr_data, s_rd_data;
  logic [3:0]        s_wr_req, s_wr_ack, s_rd_req, s_rd_ack;
  logic [9:0]        wr_addr, rd_addr;
  logic [31:0]       wr_data, rd_data;
  logic              wr_req, wr_ack, rd_req, rd_ack;
  logic              wr_timeout, rd_timeout;
  logic [15:0]       wr_timeout_cnt, rd_timeout_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfr_ipif_arbiter #(
    .IPIF_ADDR_WIDTH (10),
    .IPIF_DATA_WIDTH (32),
    .NUM_REQ         (4),
    .TIMEOUT         (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_wr_addr      (s_wr_addr),
    .s_wr_req       (s_wr_req),
    .s_wr_data      (s_wr_data),
    .s_wr_ack       (s_wr_ack),
    .s_rd_addr      (s_rd_addr),
    .s_rd_req       (s_rd_req),
    .s_rd_data      (s_rd_data),
    .s_rd_ack       (s_rd_ack),
    .wr_addr        (wr_addr),
    .wr_req         (wr_req),
    .wr_data        (wr_data),
    .wr_ack         (wr_ack),
    .rd_addr        (rd_addr),
    .rd_req         (rd_req),
    .rd_data        (rd_data),
    .rd_ack         (rd_ack),
    .wr_timeout     (wr_timeout),
    .rd_timeout     (rd_timeout),
    .wr_timeout_cnt (wr_timeout_cnt),
    .rd_timeout_cnt (rd_timeout_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [9:0] rd_addrs[4];
  logic [9:0] fair_addrs[3];
  logic [3:0] fair_acks[3];
  int         nreq, nack, last_c, ngr;
  logic       ack_next, ack_to0;
  logic [31:0] ack_dat;

  initial begin
    rst = 1'b1;
    s_wr_addr = '0; s_wr_data = '0; s_wr_req = '0;
    s_rd_addr = '0; s_rd_req = '0;
    wr_ack = 1'b0; rd_ack = 1'b0; rd_data = '0;
    repeat (3) cyc();
    check("reset_wr_req", wr_req, 1'b0);
    check("reset_acks", {s_wr_ack, s_rd_ack}, 8'h00);
    check("reset_rd_data", s_rd_data, 128'h0);
    check("reset_cnt", {wr_timeout_cnt, rd_timeout_cnt}, 32'h0);
    rst = 1'b0;

    // Single write from requester 0, downstream acks two cycles after issue.
    cyc(); s_wr_addr[0] = 10'h012; s_wr_data[0] = 32'h1234_5678; s_wr_req = 4'b0001;
    cyc(); s_wr_req = '0; check("t1_no_early_req", wr_req, 1'b0);
    cyc(); check("t1_wr_req", wr_req, 1'b1);
    check("t1_wr_addr", wr_addr, 10'h012);
    check("t1_wr_data", wr_data, 32'h1234_5678);
    cyc(); check("t1_req_pulse", wr_req, 1'b0);
    cyc(); wr_ack = 1'b1; check("t1_no_early_ack", s_wr_ack, 4'b0000);
    cyc(); wr_ack = 1'b0;
    check("t1_s_wr_ack", s_wr_ack, 4'b0001);
    check("t1_no_timeout", wr_timeout, 1'b0);
    cyc(); check("t1_ack_pulse", s_wr_ack, 4'b0000);
    check("t1_addr_hold", wr_addr, 10'h012);

    // Four simultaneous reads, each acked one cycle after issue with data = address.
    rd_addrs = '{10'h010, 10'h021, 10'h032, 10'h3FF};
    cyc();
    for (int i = 0; i < 4; i++) s_rd_addr[i] = rd_addrs[i];
    s_rd_req = 4'hF;
    cyc(); s_rd_req = '0;
    nreq = 0; nack = 0; last_c = 0; ack_next = 1'b0; ack_dat = '0;
    for (int c = 0; c < 40 && nack < 4; c++) begin
      cyc();
      rd_ack = ack_next; rd_data = ack_dat; ack_next = 1'b0;
      if (rd_req) begin
        if (nreq < 4) check("t2_grant_addr", rd_addr, rd_addrs[nreq]);
        if (nreq > 0) check("t2_spacing", c - last_c, 3);
        last_c = c; nreq++; ack_next = 1'b1; ack_dat = {22'b0, rd_addr};
      end
      if (s_rd_ack != 4'b0000) begin
        check("t2_ack_order", s_rd_ack, 4'b0001 << nack);
        nack++;
      end
    end
    rd_ack = 1'b0;
    check("t2_all_acked", nack, 4);
    check("t2_rd_data", s_rd_data, {32'h3FF, 32'h032, 32'h021, 32'h010});

    // Fairness: requester 0 re-requests in each of its downstream ack cycles.
    fair_addrs = '{10'h0A0, 10'h0C2, 10'h0A1};
    fair_acks  = '{4'b0001, 4'b0100, 4'b0001};
    cyc(); s_wr_addr[0] = 10'h0A0; s_wr_data[0] = 32'hA0A0_0000; s_wr_req = 4'b0001;
    cyc(); s_wr_addr[2] = 10'h0C2; s_wr_data[2] = 32'hC2C2_0002; s_wr_req = 4'b0100;
    ngr = 0; nack = 0; ack_next = 1'b0; ack_to0 = 1'b0;
    for (int c = 0; c < 60 && nack < 3; c++) begin
      cyc();
      s_wr_req = '0; wr_ack = ack_next;
      if (ack_next && ack_to0 && ngr < 3) begin
        s_wr_addr[0] = 10'h0A1; s_wr_req = 4'b0001;
      end
      ack_next = 1'b0;
      if (wr_req) begin
        if (ngr < 3) check("t3_grant_addr", wr_addr, fair_addrs[ngr]);
        if (ngr == 1) check("t3_grant_data", wr_data, 32'hC2C2_0002);
        ack_to0 = (ngr != 1); ngr++; ack_next = 1'b1;
      end
      if (s_wr_ack != 4'b0000) begin
        if (nack < 3) check("t3_ack", s_wr_ack, fair_acks[nack]);
        nack++;
      end
    end
    wr_ack = 1'b0; s_wr_req = '0;
    check("t3_all_acked", nack, 3);

    // Read from requester 1 never acked: timeout after 8 wait cycles, late ack dropped.
    cyc(); s_rd_addr[1] = 10'h111; s_rd_req = 4'b0010;
    cyc(); s_rd_req = '0;
    cyc(); check("t4_rd_req", rd_req, 1'b1); check("t4_rd_addr", rd_addr, 10'h111);
    for (int k = 1; k <= 8; k++) begin
      cyc(); check("t4_waiting", {s_rd_ack, rd_timeout}, 5'b0);
    end
    cyc();
    check("t4_to_ack", s_rd_ack, 4'b0010);
    check("t4_to_pulse", rd_timeout, 1'b1);
    check("t4_to_data", s_rd_data[1], 32'hDEAD_BEEF);
    check("t4_to_cnt", rd_timeout_cnt, 16'd1);
    cyc(); check("t4_to_pulse_end", rd_timeout, 1'b0);
    cyc();
    cyc(); rd_ack = 1'b1; rd_data = 32'h0000_0077;
    cyc(); rd_ack = 1'b0;
    check("t4_late_ack_dropped", s_rd_ack, 4'b0000);
    check("t4_cnt_hold", rd_timeout_cnt, 16'd1);
    check("t4_data_hold", s_rd_data[1], 32'hDEAD_BEEF);
    check("t4_other_hold", s_rd_data[0], 32'h0000_0010);

    // Ack lands in the very cycle the timer expires: counts as a normal ack.
    cyc(); s_rd_addr[2] = 10'h222; s_rd_req = 4'b0100;
    cyc(); s_rd_req = '0;
    cyc(); check("t4b_rd_req", rd_req, 1'b1);
    repeat (7) cyc();
    cyc(); rd_ack = 1'b1; rd_data = 32'h0000_0055;
    cyc(); rd_ack = 1'b0;
    check("t4b_ack", s_rd_ack, 4'b0100);
    check("t4b_no_timeout", rd_timeout, 1'b0);
    check("t4b_data", s_rd_data[2], 32'h0000_0055);
    check("t4b_cnt", rd_timeout_cnt, 16'd1);

    // Concurrent write and read from requester 3.
    cyc();
    s_wr_addr[3] = 10'h333; s_wr_data[3] = 32'h3333_3333; s_rd_addr[3] = 10'h3A3;
    s_wr_req = 4'b1000; s_rd_req = 4'b1000;
    cyc(); s_wr_req = '0; s_rd_req = '0;
    cyc();
    check("t5_both_req", {wr_req, rd_req}, 2'b11);
    check("t5_wr_addr", wr_addr, 10'h333);
    check("t5_wr_data", wr_data, 32'h3333_3333);
    check("t5_rd_addr", rd_addr, 10'h3A3);
    cyc(); wr_ack = 1'b1;
    cyc(); wr_ack = 1'b0;
    check("t5_wr_ack", {s_wr_ack, s_rd_ack}, 8'b1000_0000);
    cyc(); rd_ack = 1'b1; rd_data = 32'hA5A5_A5A5;
    cyc(); rd_ack = 1'b0;
    check("t5_rd_ack", {s_wr_ack, s_rd_ack}, 8'b0000_1000);
    check("t5_rd_data", s_rd_data[3], 32'hA5A5_A5A5);

    // Completed write from requester 2 moves the pointer past 2.
    cyc(); s_wr_addr[2] = 10'h202; s_wr_data[2] = 32'h2222_2222; s_wr_req = 4'b0100;
    cyc(); s_wr_req = '0;
    cyc(); check("t6_pre_req", wr_addr, 10'h202);
    cyc(); wr_ack = 1'b1;
    cyc(); wr_ack = 1'b0; check("t6_pre_ack", s_wr_ack, 4'b0100);

    // Reset while requester 1's write waits.
    cyc(); s_wr_addr[1] = 10'h1F1; s_wr_data[1] = 32'h1111_1111; s_wr_req = 4'b0010;
    cyc(); s_wr_req = '0;
    cyc(); check("t6_inflight", wr_req, 1'b1);
    cyc(); rst = 1'b1;
    cyc();
    check("t6_rst_ds", {wr_req, rd_req, wr_addr, wr_data, rd_addr}, 54'h0);
    check("t6_rst_acks", {s_wr_ack, s_rd_ack, wr_timeout, rd_timeout}, 10'h0);
    check("t6_rst_rd_data", s_rd_data, 128'h0);
    check("t6_rst_cnt", rd_timeout_cnt, 16'd0);
    rst = 1'b0; wr_ack = 1'b1;
    cyc(); wr_ack = 1'b0;
    check("t6_abandoned", s_wr_ack, 4'b0000);
    s_wr_addr[1] = 10'h101; s_wr_addr[3] = 10'h303; s_wr_req = 4'b1010;
    cyc(); s_wr_req = '0; check("t6_no_ack", s_wr_ack, 4'b0000);
    cyc(); check("t6_regrant_req", wr_req, 1'b1);
    check("t6_regrant_addr", wr_addr, 10'h101);
    cyc(); wr_ack = 1'b1;
    cyc(); wr_ack = 1'b0; check("t6_regrant_ack", s_wr_ack, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfr_ipif_arbiter.md
Name: cfr_ipif_arbiter

Overview:
- Shares one downstream IPIF port, which feeds the CFR IPIF mux, between NUM_REQ independent IPIF requesters (e.g. host AXI-lite bridge, coefficient loader, calibration sequencer).
- Write and read channels are arbitrated independently, each with round-robin fairness and one outstanding transaction.
- A per-channel timeout guarantees every requester receives an ack even if the addressed branch never answers.

Parameters:
- IPIF_ADDR_WIDTH, 10, address width on all ports
- IPIF_DATA_WIDTH, 32, data width on all ports
- NUM_REQ, 4, number of requesters (2..16)
- TIMEOUT, 255, cycles to wait for downstream ack after issue; 0 disables timeout
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on read timeout

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- s_wr_addr  in  [NUM_REQ][IPIF_ADDR_WIDTH]  requester write address
- s_wr_req  in  [NUM_REQ]  requester write request, 1-cycle pulse
- s_wr_data  in  [NUM_REQ][IPIF_DATA_WIDTH]  requester write data
- s_wr_ack  out  [NUM_REQ]  write ack to requester, 1-cycle pulse
- s_rd_addr  in  [NUM_REQ][IPIF_ADDR_WIDTH]  requester read address
- s_rd_req  in  [NUM_REQ]  requester read request, 1-cycle pulse
- s_rd_data  out  [NUM_REQ][IPIF_DATA_WIDTH]  read data, valid with s_rd_ack
- s_rd_ack  out  [NUM_REQ]  read ack, 1-cycle pulse
- wr_addr / wr_req / wr_data  out  IPIF_ADDR_WIDTH / 1 / IPIF_DATA_WIDTH  downstream write
- wr_ack  in  1  downstream write ack
- rd_addr / rd_req  out  IPIF_ADDR_WIDTH / 1  downstream read
- rd_data / rd_ack  in  IPIF_DATA_WIDTH / 1  downstream read return
- wr_timeout / rd_timeout  out  1  1-cycle pulse on a timeout event
- wr_timeout_cnt / rd_timeout_cnt  out  16  saturating timeout counters

Behaviour:
- Interface decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - All outputs 0; all pending flags cleared; timeout counters 0.
  - Round-robin pointer points at requester 0.
  - A transaction in flight is abandoned, with no ack to the requester.
  - Acks arriving in the first cycle after reset is released are ignored.
- Capture: s_*_req[i] at cycle t sets pending[i] and registers addr/data at t+1.
  - A req while pending[i] is already set is ignored; the first-captured addr/data are kept.
  - A req in the same cycle as s_*_ack[i] is a new request (set wins over clear).
- Per-channel FSM: IDLE, WAIT.
  - IDLE: if any pending, grant the first pending index searching from (last_grant+1) mod NUM_REQ.
  - On grant, drive the downstream addr/data registered and pulse req for exactly 1 cycle (cycle t+2 for an isolated request at t). Go to WAIT; load the timeout counter.
  - WAIT, ack: go to IDLE. Next cycle, pulse s_*_ack[g] and clear pending[g]; a read also registers s_rd_data[g] = rd_data. last_grant = g.
  - WAIT, no ack for TIMEOUT cycles after the req cycle: go to IDLE. Pulse s_*_ack[g]; s_rd_data[g] = TIMEOUT_DATA; pulse *_timeout; increment the counter, saturating at 16'hFFFF.
  - TIMEOUT=0: WAIT exits only on ack.
- Downstream acks in IDLE (late or spurious) are dropped.
- An ack in the same cycle the timeout expires counts as a normal ack; no timeout is recorded.
- Downstream addr/data outputs hold their last values between transactions.
- s_rd_data[i] holds until that requester's next read ack.
- Channels are fully independent. Simultaneous write and read, to the same or different requesters, proceed in parallel.
- Throughput: at most one transaction per 3 cycles per channel (issue, ack, return to IDLE). Back-to-back pending requests are re-arbitrated in IDLE immediately.

Decomposition:
- cfr_ipif_pkg:
  - ipif_arb_state_t enum {IDLE, WAIT}
  - default TIMEOUT_DATA constant
  - function rr_pick(pending, last) returning the next grant index
- Sub-module cfr_ipif_arb_ch, instantiated twice:
  - Generic channel containing the capture latches, round-robin grant, FSM, timeout and counters.
  - Carries a forward payload (addr + wr_data for the write channel, addr only for read) and a return payload (0 for write, rd_data for read).
  - A parameter selects whether the return payload is registered per requester.

Test Plan:
- Single write, req0 addr 0x012 data 0x1234_5678 at t; downstream acks at t+4 -> wr_req at t+2 with those values; s_wr_ack[0] at t+5; no timeout.
- Requesters 0..3 all read-request in the same cycle, each downstream read acked 1 cycle after req with data = addr -> grants in order 0,1,2,3; each s_rd_data[i] holds its own address.
- Fairness: req0 re-requests every cycle it is acked, req2 requests once -> req2 granted immediately after req0's first transaction completes.
- TIMEOUT=8, downstream never acks read from req1 -> s_rd_ack[1] 8 cycles after rd_req (+1 registration); data 0xDEAD_BEEF; rd_timeout pulse; rd_timeout_cnt=1. A late rd_ack 3 cycles later is ignored.
- Concurrent: write from req3 and read from req3 in the same cycle -> wr_req and rd_req issue in the same cycle; both acks return independently.
- Reset mid-WAIT: assert rst while a write waits -> all outputs 0 the next cycle; no s_wr_ack is produced. A new request after reset is granted to the lowest pending index starting at 0.
